// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Command-FIFO front end for an APB master. Read/write commands arrive on a
//   valid/ready port and are buffered in a small FIFO. Each command is issued
//   as a SETUP + ACCESS transfer. Every completed transfer produces a
//   one-cycle response pulse; reads carry PRDATA in that pulse.
//
//   Optional feature: define APB_MASTER_PREADY_EN to add the PREADY input and
//   the wait_cycles output. With it, ACCESS is extended by slave wait states.
//   Without it, ACCESS is always a single cycle.
//
//   Reset: PRESET is synchronous and active-high.
module apb_master_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          PRESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [DATA_W-1:0]             cmd_wdata,
  output logic                          rsp_valid,
  output logic                          rsp_write,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [ADDR_W-1:0]             PADDR,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [DATA_W-1:0]             PWDATA,
  input  logic [DATA_W-1:0]             PRDATA,
  output logic                          busy,
`ifdef APB_MASTER_PREADY_EN
  input  logic                          PREADY,
  output logic [15:0]                   wait_cycles,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [CMD_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;

  logic              full_s;
  logic              empty_s;
  logic              cmd_ready_s;
  logic              push_s;
  logic              pop_s;
  logic [CMD_W-1:0]  head_s;
  logic              head_write_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_wdata_s;

  // ---------------------------------------------------------------------
  // Transfer FSM and registered APB / response outputs
  // ---------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              access_done_s;
`ifdef APB_MASTER_PREADY_EN
  logic [15:0]       wait_q, wait_d;
`endif

  // A full FIFO refuses new commands even when a pop happens this cycle.
  // This keeps cmd_ready a pure function of registered state and PRESET.
  assign full_s       = (count_q == DEPTH_C);
  assign empty_s      = (count_q == {(PTR_W+1){1'b0}});
  assign cmd_ready_s  = !full_s && !PRESET;
  assign push_s       = cmd_valid && cmd_ready_s;

  assign head_s       = mem_q[rd_ptr_q];
  assign head_write_s = head_s[CMD_W-1];
  assign head_addr_s  = head_s[ADDR_W+DATA_W-1:DATA_W];
  assign head_wdata_s = head_s[DATA_W-1:0];

`ifdef APB_MASTER_PREADY_EN
  assign access_done_s = (state_q == ST_ACCESS) && PREADY;
`else
  assign access_done_s = (state_q == ST_ACCESS);
`endif

  // A command leaves the FIFO on the edge that enters SETUP.
  assign pop_s = !empty_s && ((state_q == ST_IDLE) || access_done_s);

  // Store accepted commands. The storage has no reset because it is only
  // read through the pointers, and the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally at a
  // power-of-two depth.
  always_ff @(posedge clk) begin
    if (PRESET) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state and next-output logic of the SETUP/ACCESS sequencer.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = {DATA_W{1'b0}};
`ifdef APB_MASTER_PREADY_EN
    wait_d      = wait_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = head_addr_s;
          pwrite_d  = head_write_s;
          // A read leaves PWDATA at its previous value.
          if (head_write_s) begin
            pwdata_d = head_wdata_s;
          end else begin
            pwdata_d = pwdata_q;
          end
`ifdef APB_MASTER_PREADY_EN
          wait_d = 16'h0000;
`endif
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (access_done_s) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          if (pwrite_q) begin
            rsp_rdata_d = {DATA_W{1'b0}};
          end else begin
            rsp_rdata_d = PRDATA;
          end
          if (!empty_s) begin
            // Back-to-back transfer: PSEL stays high and PENABLE drops.
            state_d   = ST_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = head_addr_s;
            pwrite_d  = head_write_s;
            if (head_write_s) begin
              pwdata_d = head_wdata_s;
            end else begin
              pwdata_d = pwdata_q;
            end
`ifdef APB_MASTER_PREADY_EN
            wait_d = 16'h0000;
`endif
          end else begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else begin
          // The slave is inserting wait states. All APB outputs are held.
`ifdef APB_MASTER_PREADY_EN
          if (wait_q != 16'hFFFF) begin
            wait_d = wait_q + 16'd1;
          end else begin
            wait_d = wait_q;
          end
`endif
          state_d = ST_ACCESS;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State register and registered outputs. Reset also aborts any transfer
  // in flight without producing a response.
  always_ff @(posedge clk) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      pwrite_q    <= 1'b0;
      pwdata_q    <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
`ifdef APB_MASTER_PREADY_EN
      wait_q      <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_PREADY_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_s;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign busy       = (state_q != ST_IDLE) || !empty_s;
  assign fifo_count = count_q;
`ifdef APB_MASTER_PREADY_EN
  assign wait_cycles = wait_q;
`endif

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream stage that drives the APB bus: accepts simple read/write commands on a valid/ready port and buffers them in a small command FIFO.
- Issues each command as a two-phase APB transfer (SETUP then ACCESS) on PSEL/PENABLE/PADDR/PWRITE/PWDATA.
- Returns a one-cycle response pulse carrying PRDATA for reads.
- Sits directly in front of the APB interface and its PSEL/PENABLE protocol checker.

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR.
- DATA_W, 32, width of write/read data.
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- PRESET  input  1  synchronous active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  transfer address.
- cmd_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse per completed transfer.
- rsp_write  output  1  direction of the completed transfer.
- rsp_rdata  output  DATA_W  PRDATA for reads, 0 for writes.
- PADDR  output  ADDR_W  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_W  APB write data.
- PRDATA  input  DATA_W  APB read data.
- busy  output  1  FSM not IDLE or FIFO non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Clock is clk; reset is PRESET, synchronous, active-high.
- Reset (any cycle): all outputs 0 (cmd_ready reads 1 after reset releases), FIFO flushed, FSM to IDLE.
- Reset mid-transfer: PSEL/PENABLE are 0 after the reset edge; no rsp_valid is produced for the aborted command.
- Push: cmd_valid && cmd_ready at an edge. When full, cmd_ready=0 even if a pop occurs in the same cycle.
- Pop: occurs on the edge entering SETUP.
- Simultaneous push and pop leaves fifo_count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE -> SETUP when FIFO non-empty:
  - PSEL=1, PENABLE=0.
  - PADDR/PWRITE/PWDATA loaded from the FIFO head.
- SETUP -> ACCESS unconditionally: PENABLE=1; PADDR/PWRITE/PWDATA held.
- ACCESS lasts 1 cycle without the optional feature. At its closing edge:
  - PRDATA is sampled.
  - rsp_valid=1 for exactly one cycle, with rsp_write=PWRITE and rsp_rdata=(PWRITE ? 0 : PRDATA).
- ACCESS -> SETUP if FIFO non-empty at that edge (back-to-back): PSEL stays 1, PENABLE drops to 0, new command loaded.
- ACCESS -> IDLE otherwise: PSEL=0, PENABLE=0.
- In IDLE, PADDR/PWRITE/PWDATA hold their last values. Reads also leave PWDATA unchanged.
- Latency:
  - PSEL rises at the edge after the acceptance edge when the FIFO was empty and the FSM was idle.
  - rsp_valid asserts 2 cycles after PSEL rises.
  - Sustained throughput: one transfer per 2 cycles.
- Invariants:
  - PENABLE=1 implies PSEL=1.
  - PENABLE is never 1 for two consecutive cycles without PREADY support.
- rsp has no backpressure; the consumer must take it.

Optional Feature:
- Macro APB_MASTER_PREADY_EN.
- When defined:
  - Adds input port PREADY (1 bit).
  - ACCESS holds (PSEL=1, PENABLE=1, all APB outputs stable) until PREADY=1.
  - The ACCESS exit, PRDATA sampling and rsp_valid all occur at the edge where PREADY=1.
  - Adds output wait_cycles (16 bits): stall cycles of the current transfer, cleared on entering SETUP, saturating at 16'hFFFF.
- When undefined: no PREADY or wait_cycles ports; ACCESS is always exactly 1 cycle.

Test Plan:
- Single write: cmd (write=1, addr=32'h10, wdata=32'hDEADBEEF) while idle -> PSEL high next cycle, PENABLE high the cycle after with PADDR=32'h10 and PWDATA=32'hDEADBEEF; rsp_valid=1 with rsp_write=1 and rsp_rdata=0; then PSEL=PENABLE=0.
- Single read: read addr 32'h24, PRDATA=32'hCAFE0001 during ACCESS -> rsp_valid pulse with rsp_rdata=32'hCAFE0001 and rsp_write=0.
- Back-to-back: 3 commands on consecutive cycles -> PSEL continuously 1 for 6 cycles; PENABLE pattern 0,1,0,1,0,1; 3 rsp_valid pulses in order; busy falls after the last one.
- FIFO full: FIFO_DEPTH=4, hold cmd_valid for 6 commands -> cmd_ready drops when fifo_count=4; no command lost or duplicated; responses match issue order.
- Reset mid-operation: PRESET=1 during ACCESS with 2 commands queued -> after the edge PSEL=PENABLE=0, fifo_count=0, no rsp_valid, cmd_ready=1 once PRESET=0.
- With APB_MASTER_PREADY_EN: PREADY held 0 for 3 ACCESS cycles then 1 -> PENABLE high for 4 cycles with APB outputs stable; wait_cycles reaches 3; single rsp_valid.
